// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fixed-latency memory sequencer shared by fetch and data ports
module mem_arbiter #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic [15:0] i_data,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  input  logic        halt,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  output logic        m_en,
  output logic        m_wr,
  output logic        m_dump,
  input  logic [15:0] m_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DUMP   = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        wr_q;
  logic        busy;
  logic        d_want;
  logic        i_want;

  // A port whose done pulse is showing is still holding its old request; ignore it this cycle.
  assign d_want = (d_rd | d_wr) & ~d_done;
  assign i_want = i_req & ~i_done;

  assign i_stall = i_req & ~i_done;
  assign d_stall = (d_rd | d_wr) & ~d_done;

  // Memory-side strobes decode directly from registered state so they carry no input-to-output path.
  assign busy    = (state == BUSY_I) || (state == BUSY_D);
  assign m_en    = busy;
  assign m_addr  = busy ? addr_q : 16'h0000;
  assign m_wdata = busy ? wdata_q : 16'h0000;
  assign m_wr    = busy & wr_q & (cnt == 4'd0);
  assign m_dump  = (state == DUMP);

  // Arbitration, access sequencing and completion capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      wr_q    <= 1'b0;
      i_data  <= 16'h0000;
      d_rdata <= 16'h0000;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (state)
        IDLE: begin
          if (halt) begin
            state <= DUMP;
          end else if (d_want) begin
            // Data goes first: the memory-stage instruction is older than the fetch.
            state   <= BUSY_D;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
            wr_q    <= d_wr;
            cnt     <= CNT_INIT;
          end else if (i_want) begin
            state   <= BUSY_I;
            addr_q  <= i_addr;
            wdata_q <= 16'h0000;
            wr_q    <= 1'b0;
            cnt     <= CNT_INIT;
          end
        end
        BUSY_I, BUSY_D: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (state == BUSY_I) begin
              i_data <= m_rdata;
              i_done <= 1'b1;
            end else begin
              if (!wr_q) d_rdata <= m_rdata;
              d_done <= 1'b1;
            end
            state <= IDLE;
          end
        end
        DUMP: begin
          state <= HALTED;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;

  localparam int LAT = 3;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic [15:0] i_data;
  logic        i_done;
  logic        i_stall;
  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_stall;
  logic        halt;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_en;
  logic        m_wr;
  logic        m_dump;
  logic [15:0] m_rdata;

  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [15:0] bd_data;
  logic [15:0] mem     [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic [15:0] model_drd;

  int checks = 0;
  int passes = 0;
  int en_cnt = 0;
  int wr_cnt = 0;
  int dump_cnt = 0;

  mem_arbiter #(.LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_done(i_done), .i_stall(i_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .halt(halt),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_en(m_en), .m_wr(m_wr),
    .m_dump(m_dump), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory stand-in: combinational read, write on the clock edge, plus activity counters.
  assign m_rdata = mem[m_addr[9:0]];
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (m_en && m_wr) mem[m_addr[9:0]] <= m_wdata;
    if (m_en) en_cnt <= en_cnt + 1;
    if (m_wr) wr_cnt <= wr_cnt + 1;
    if (m_dump) dump_cnt <= dump_cnt + 1;
  end

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; halt = 1'b0;
    i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0; bd_we = 1'b0;
    bd_addr = 10'h0; bd_data = 16'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic poke(input logic [9:0] a, input logic [15:0] v);
    bd_addr = a; bd_data = v; bd_we = 1'b1;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic test_reset();
    int e0;
    do_reset();
    e0 = en_cnt;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({i_done, d_done, i_data, d_rdata, m_en, m_wr, m_dump, m_addr, m_wdata, i_stall, d_stall} !== '0)
        $display("FAIL reset_idle c=%0d: got i_done=%b d_done=%b i_data=%h d_rdata=%h m_en=%b m_wr=%b m_dump=%b m_addr=%h m_wdata=%h, want all 0",
                 c, i_done, d_done, i_data, d_rdata, m_en, m_wr, m_dump, m_addr, m_wdata);
      else passes++;
      @(posedge clk); #1;
    end
    checks++;
    if (en_cnt - e0 !== 0) $display("FAIL reset_no_en: got %0d m_en cycles want 0", en_cnt - e0);
    else passes++;
  endtask

  task automatic test_fetch_read();
    logic ee, ed, es;
    int e0;
    poke(10'h040, 16'hBEEF);
    e0 = en_cnt;
    i_req = 1'b1; i_addr = 16'h0040;
    for (int c = 0; c <= LAT + 3; c++) begin
      @(negedge clk);
      ee = (c >= 1 && c <= LAT); ed = (c == LAT + 1); es = (c <= LAT);
      checks++;
      if ({m_en, i_done, i_stall} !== {ee, ed, es})
        $display("FAIL fetch_timing c=%0d: got en/done/stall=%b%b%b want %b%b%b", c, m_en, i_done, i_stall, ee, ed, es);
      else passes++;
      if (ee) begin
        checks++;
        if (m_addr !== 16'h0040) $display("FAIL fetch_addr c=%0d: got %h want 0040", c, m_addr);
        else passes++;
      end
      if (ed || c == LAT + 3) begin
        checks++;
        if (i_data !== 16'hBEEF) $display("FAIL fetch_data c=%0d: got %h want beef", c, i_data);
        else passes++;
      end
      @(posedge clk); #1;
      if (c == LAT + 1) i_req = 1'b0;
    end
    checks++;
    if (en_cnt - e0 !== LAT) $display("FAIL fetch_en_count: got %0d want %0d", en_cnt - e0, LAT);
    else passes++;
  endtask

  task automatic test_contention();
    logic edd, eid, ee;
    poke(10'h100, 16'h1234);
    poke(10'h044, 16'h4444);
    i_req = 1'b1; i_addr = 16'h0044;
    d_rd = 1'b1; d_addr = 16'h0100;
    for (int c = 0; c <= 2 * LAT + 3; c++) begin
      @(negedge clk);
      edd = (c == LAT + 1); eid = (c == 2 * LAT + 2);
      ee = (c >= 1 && c <= LAT) || (c >= LAT + 2 && c <= 2 * LAT + 1);
      checks++;
      if ({d_done, i_done, m_en} !== {edd, eid, ee})
        $display("FAIL contention_timing c=%0d: got d_done/i_done/m_en=%b%b%b want %b%b%b", c, d_done, i_done, m_en, edd, eid, ee);
      else passes++;
      if (edd) begin
        checks++;
        if (d_rdata !== 16'h1234) $display("FAIL contention_ddata: got %h want 1234", d_rdata);
        else passes++;
      end
      if (eid) begin
        checks++;
        if (i_data !== 16'h4444) $display("FAIL contention_idata: got %h want 4444", i_data);
        else passes++;
      end
      if (c == LAT + 2) begin
        checks++;
        if (m_addr !== 16'h0044) $display("FAIL contention_fetch_addr: got %h want 0044", m_addr);
        else passes++;
      end
      @(posedge clk); #1;
      if (c == LAT + 1) d_rd = 1'b0;
      if (c == 2 * LAT + 2) i_req = 1'b0;
    end
    model_drd = 16'h1234;
  endtask

  task automatic test_write();
    logic ee, ew, ed;
    int w0;
    poke(10'h200, 16'h7777);
    w0 = wr_cnt;
    d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'hA5A5;
    for (int c = 0; c <= 2 * LAT + 4; c++) begin
      @(negedge clk);
      ee = (c >= 1 && c <= LAT) || (c >= LAT + 3 && c <= 2 * LAT + 2);
      ew = (c == LAT);
      ed = (c == LAT + 1) || (c == 2 * LAT + 3);
      checks++;
      if ({m_en, m_wr, d_done} !== {ee, ew, ed})
        $display("FAIL write_timing c=%0d: got en/wr/done=%b%b%b want %b%b%b", c, m_en, m_wr, d_done, ee, ew, ed);
      else passes++;
      if (ew) begin
        checks++;
        if ({m_addr, m_wdata} !== {16'h0200, 16'hA5A5})
          $display("FAIL write_bus: got addr=%h data=%h want 0200 a5a5", m_addr, m_wdata);
        else passes++;
      end
      if (c == LAT + 1) begin
        checks++;
        if (d_rdata !== model_drd) $display("FAIL write_rdata_held: got %h want %h", d_rdata, model_drd);
        else passes++;
      end
      if (c == 2 * LAT + 3) begin
        checks++;
        if (d_rdata !== 16'hA5A5) $display("FAIL write_readback: got %h want a5a5", d_rdata);
        else passes++;
      end
      @(posedge clk); #1;
      if (c == LAT) begin d_wr = 1'b0; d_rd = 1'b1; end
      if (c == 2 * LAT + 3) d_rd = 1'b0;
    end
    model_drd = 16'hA5A5;
    checks++;
    if (wr_cnt - w0 !== 1) $display("FAIL write_count: got %0d want 1", wr_cnt - w0);
    else passes++;
  endtask

  task automatic test_halt();
    logic edd, edm, ee, es;
    int k0;
    do_reset();
    k0 = dump_cnt;
    d_rd = 1'b1; d_addr = 16'h0100;
    for (int c = 0; c <= LAT + 10; c++) begin
      @(negedge clk);
      edd = (c == LAT + 1); edm = (c == LAT + 2); ee = (c >= 1 && c <= LAT);
      es = (c >= LAT + 4);
      checks++;
      if ({d_done, m_dump, m_en, i_done, i_stall} !== {edd, edm, ee, 1'b0, es})
        $display("FAIL halt_timing c=%0d: got d_done/dump/en/i_done/i_stall=%b%b%b%b%b want %b%b%b0%b",
                 c, d_done, m_dump, m_en, i_done, i_stall, edd, edm, ee, es);
      else passes++;
      if (edd) begin
        checks++;
        if (d_rdata !== 16'h1234) $display("FAIL halt_ddata: got %h want 1234", d_rdata);
        else passes++;
      end
      @(posedge clk); #1;
      if (c == 1) halt = 1'b1;
      if (c == LAT + 1) d_rd = 1'b0;
      if (c == LAT + 3) begin i_req = 1'b1; i_addr = 16'h0040; end
    end
    checks++;
    if (dump_cnt - k0 !== 1) $display("FAIL halt_dump_count: got %0d want 1", dump_cnt - k0);
    else passes++;
  endtask

  task automatic test_halt_priority();
    logic edm;
    int e0, w0;
    do_reset();
    e0 = en_cnt; w0 = wr_cnt;
    halt = 1'b1; i_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0300; d_wdata = 16'hFFFF;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      edm = (c == 1);
      checks++;
      if ({m_dump, i_done, d_done, d_stall, i_stall} !== {edm, 4'b0011})
        $display("FAIL halt_prio c=%0d: got dump/i_done/d_done/d_stall/i_stall=%b%b%b%b%b want %b0011",
                 c, m_dump, i_done, d_done, d_stall, i_stall, edm);
      else passes++;
      @(posedge clk); #1;
    end
    checks++;
    if ((en_cnt - e0 !== 0) || (wr_cnt - w0 !== 0))
      $display("FAIL halt_prio_noaccess: got en=%0d wr=%0d want 0 0", en_cnt - e0, wr_cnt - w0);
    else passes++;
  endtask

  task automatic test_reset_mid_write();
    int w0;
    logic ed;
    do_reset();
    poke(10'h210, 16'h1111);
    w0 = wr_cnt;
    d_wr = 1'b1; d_addr = 16'h0210; d_wdata = 16'h5A5A;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) begin
        checks++;
        if ({i_done, d_done, i_data, d_rdata, m_en, m_wr, m_dump, m_addr, m_wdata} !== '0)
          $display("FAIL rstmid_outputs: got m_en=%b m_wr=%b m_addr=%h m_wdata=%h d_done=%b, want all 0",
                   m_en, m_wr, m_addr, m_wdata, d_done);
        else passes++;
      end
      @(posedge clk); #1;
      if (c == 1) begin rst = 1'b1; d_wr = 1'b0; end
      if (c == 2) rst = 1'b0;
    end
    checks++;
    if (wr_cnt - w0 !== 0) $display("FAIL rstmid_no_write: got %0d writes want 0", wr_cnt - w0);
    else passes++;
    d_rd = 1'b1; d_addr = 16'h0210;
    for (int c = 0; c <= LAT + 2; c++) begin
      @(negedge clk);
      ed = (c == LAT + 1);
      checks++;
      if (d_done !== ed) $display("FAIL rstmid_fresh_done c=%0d: got %b want %b", c, d_done, ed);
      else passes++;
      if (ed) begin
        checks++;
        if (d_rdata !== 16'h1111) $display("FAIL rstmid_fresh_data: got %h want 1111", d_rdata);
        else passes++;
      end
      @(posedge clk); #1;
      if (c == LAT + 1) d_rd = 1'b0;
    end
  endtask

  // Transaction-level model: a lone access finishes LAT+1 cycles after its request; when both
  // ports ask together data goes first and fetch finishes one further LAT+1 later.
  task automatic test_random();
    int kind, use_i, use_d, dwr, ai, ad, t_i, t_d, nd, ni, gd, gi, w0, gap;
    logic [15:0] wv, ev_i, ev_d, vd, vi;
    do_reset();
    model_drd = 16'h0000;
    for (int k = 0; k < 8; k++) poke(10'(12'h300 + k), 16'($urandom));
    for (int n = 0; n < 24; n++) begin
      kind  = int'($urandom_range(0, 3));
      use_i = (kind == 0 || kind == 3) ? 1 : 0;
      use_d = (kind >= 1) ? 1 : 0;
      dwr   = (use_d == 1) ? int'($urandom_range(0, 1)) : 0;
      ai    = 'h300 + int'($urandom_range(0, 7));
      ad    = 'h300 + int'($urandom_range(0, 7));
      wv    = 16'($urandom);
      ev_d  = model_drd;
      if (use_d == 1) begin
        if (dwr == 1) ref_mem[ad] = wv;
        else begin ev_d = ref_mem[ad]; model_drd = ev_d; end
      end
      ev_i = ref_mem[ai];
      t_d  = LAT + 1;
      t_i  = (use_d == 1) ? 2 * LAT + 2 : LAT + 1;
      w0 = wr_cnt; nd = 0; ni = 0; gd = -1; gi = -1; vd = 16'h0; vi = 16'h0;
      i_req = (use_i == 1); i_addr = 16'(ai);
      d_wr = (dwr == 1);
      d_rd = (use_d == 1) && ((dwr == 0) || ($urandom_range(0, 1) == 1));
      d_addr = 16'(ad); d_wdata = wv;
      for (int c = 0; c <= 2 * LAT + 5; c++) begin
        @(negedge clk);
        if (d_done) begin nd++; gd = c; vd = d_rdata; end
        if (i_done) begin ni++; gi = c; vi = i_data; end
        @(posedge clk); #1;
        if (c == t_d) begin d_rd = 1'b0; d_wr = 1'b0; end
        if (c == t_i) i_req = 1'b0;
      end
      checks++;
      if (nd !== use_d || ni !== use_i)
        $display("FAIL rnd_pulses op=%0d: got d=%0d i=%0d want d=%0d i=%0d", n, nd, ni, use_d, use_i);
      else passes++;
      if (use_d == 1) begin
        checks++;
        if (gd !== t_d || vd !== ev_d)
          $display("FAIL rnd_data_port op=%0d: got cycle=%0d val=%h want cycle=%0d val=%h", n, gd, vd, t_d, ev_d);
        else passes++;
      end
      if (use_i == 1) begin
        checks++;
        if (gi !== t_i || vi !== ev_i)
          $display("FAIL rnd_fetch_port op=%0d: got cycle=%0d val=%h want cycle=%0d val=%h", n, gi, vi, t_i, ev_i);
        else passes++;
      end
      checks++;
      if (wr_cnt - w0 !== dwr) $display("FAIL rnd_writes op=%0d: got %0d want %0d", n, wr_cnt - w0, dwr);
      else passes++;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_drd = 16'h0000;
    test_reset();
    test_fetch_read();
    test_contention();
    test_write();
    test_halt();
    test_halt_priority();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences a single-ported, fixed-latency unified memory and shares it between the fetch stage (instruction reads) and the memory stage (data reads/writes). Requesters hold a level request and see a stall until a one-cycle done pulse returns their data. The block also serializes the halt-time memory dump so it never collides with an in-flight access. It sits between the pipeline stages and the memory2c instance.

## Interface
- LAT, 2, memory busy cycles per access; legal 1..15
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch read request, level, held until i_done
- i_addr  in  16  fetch address
- i_data  out  16  fetch read data, valid while i_done=1, held afterwards
- i_done  out  1  one-cycle completion pulse for fetch
- i_stall  out  1  i_req & ~i_done (combinational)
- d_rd  in  1  data read request, level
- d_wr  in  1  data write request, level; wins over d_rd if both high
- d_addr  in  16  data address
- d_wdata  in  16  write data
- d_rdata  out  16  data read data, valid while d_done=1, held afterwards
- d_done  out  1  one-cycle completion pulse for data port
- d_stall  out  1  (d_rd | d_wr) & ~d_done (combinational)
- halt  in  1  program halt; level
- m_addr  out  16  memory address
- m_wdata  out  16  memory write data
- m_en  out  1  memory enable
- m_wr  out  1  memory write strobe
- m_dump  out  1  memory createdump strobe
- m_rdata  in  16  memory read data (combinational from m_addr)

## Operation
- States: IDLE, BUSY_I, BUSY_D, DUMP, HALTED. Down-counter cnt (4 bits).
- IDLE arbitration, priority order: halt → DUMP; data request → BUSY_D; i_req → BUSY_I; else stay.
- Data has strict priority: the memory-stage instruction is older, and fetch stalls while it waits.
- Request suppression: a port whose done is high this cycle is ignored in this cycle's arbitration; this prevents a duplicate grant on a still-high request.
- On grant: latch the address, write data and op (rd/wr); cnt ← LAT-1.
- BUSY_x outputs: m_en=1, m_addr=latched address, m_wdata=latched data.
- BUSY_x, write op: m_wr=1 only when cnt==0, so exactly one write edge per access.
- BUSY_x, cnt>0: cnt decrements each cycle.
- BUSY_x, cnt==0: capture m_rdata into i_data/d_rdata (reads only); set done for next cycle; go to IDLE.
- Write completions pulse d_done; d_rdata is unchanged.
- halt in BUSY: the current access completes normally; halt is then taken in IDLE ahead of all requests.
- DUMP: one cycle, m_dump=1, m_en=0, m_wr=0; then go to HALTED.
- HALTED: all m_* outputs 0; requests ignored; stalls follow their formulas (never done); exit only by rst.
- Inputs other than halt/req are don't-care outside a grant; requester inputs may change after done.

## Timing
- Reset (rst=1 at an edge): state=IDLE, cnt=0.
- Reset values: i_done=d_done=0, i_data=d_rdata=0, m_en=m_wr=m_dump=0, m_addr=m_wdata=0.
- Reset mid-access aborts the access; no write is issued unless its cnt==0 edge already occurred.
- Request high in IDLE at cycle 0 → BUSY cycles 1..LAT → done=1 in cycle LAT+1.
- Total request-to-done latency is LAT+1 cycles.
- The done cycle is an IDLE cycle, in which the other port may be granted, so back-to-back accesses from alternate ports occur every LAT+1 cycles.
- Same-port back-to-back (new request raised on the done cycle): granted the following cycle, giving LAT+2 cycles per access.
- m_wr is high for exactly one cycle per write, coincident with the last m_en cycle.
- Simultaneous d_wr, i_req and halt in IDLE: DUMP wins; no access is performed.

## Test plan
- Reset then idle: all outputs 0 for 5 cycles with no requests; m_en never asserted.
- LAT=2 fetch read: mem[0x0040]=0xBEEF, i_req at cycle 0 → m_en cycles 1–2, i_done and i_data=0xBEEF at cycle 3, i_stall=1 in cycles 0–2.
- Contention: i_req and d_rd (0x0100 holds 0x1234) both raised at cycle 0 → d_done with 0x1234 at cycle 3, fetch granted at cycle 3, i_done at cycle 6.
- Write: d_wr to 0x0200 with 0xA5A5, LAT=3 → m_wr high only in cycle 3; a subsequent read returns 0xA5A5; exactly one write is observed.
- Halt during a data access in cycle 2 → access completes (d_done at cycle 3), m_dump=1 at cycle 4, then HALTED; an i_req raised later gets no i_done and no m_en.
- rst asserted in cycle 2 of a LAT=3 write → no m_wr; all outputs at reset values the next cycle; fresh request completes normally.
